l1_refill_mem: RTL

- Main-memory responder on the L1 refill interface. It watches the L1 `hit` line and `raddress`.
- On a miss it fetches the 4-word (128-bit) line containing `raddress` from an internal word array, after a programmable latency.
- It returns the line on `blockin` with a one-cycle `delivered` strobe. The L1 installs the line and then reports a hit.
- Also provides a preload port for bench/boot initialisation and a saturating miss counter.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/word_ram.sv | 24 ++
 rtl/l1_refill_mem.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the L1 refill memory responder.
package mem_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DELIVER,
    COOL
  } state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word array: combinational read, synchronous write; a same-cycle read sees the old word.
module word_ram
  import mem_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [WORDS];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/l1_refill_mem.sv
// Main-memory responder for L1 refills: on a miss, fetches the 4-word line after
// LATENCY wait cycles and presents it on blockin with a one-cycle delivered strobe.
module l1_refill_mem
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          raddress,
  input  logic                 hit,
  output logic                 delivered,
  output logic [LINE_BITS-1:0] blockin,
  output logic                 busy,
  output logic [CNT_W-1:0]     miss_count,
  input  logic                 ld_en,
  input  logic [31:0]          ld_addr,
  input  logic [31:0]          ld_data
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  state_t               state;
  logic [LAT_W-1:0]     lat_cnt;
  logic [1:0]           beat;
  logic [31:0]          lbase;
  logic [AW-1:0]        rd_idx;
  logic [AW-1:0]        wr_idx;
  logic [WORD_BITS-1:0] rd_word;
  logic                 unused_bits;

  // Address bits above the array depth alias; the line offset is always zero in lbase.
  assign rd_idx      = {lbase[AW+1:4], beat};
  assign wr_idx      = ld_addr[AW+1:2];
  assign unused_bits = ^{lbase[31:AW+2], lbase[3:0], ld_addr[31:AW+2], ld_addr[1:0]};

  word_ram #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ld_en),
    .waddr(wr_idx),
    .wdata(ld_data),
    .raddr(rd_idx),
    .rdata(rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      delivered  <= 1'b0;
      blockin    <= '0;
      busy       <= 1'b0;
      miss_count <= '0;
      beat       <= '0;
      lat_cnt    <= '0;
    end else begin
      delivered <= 1'b0;
      case (state)
        IDLE: begin
          if (!hit) begin
            lbase   <= line_base(raddress);
            lat_cnt <= LAT_W'(LATENCY);
            beat    <= '0;
            busy    <= 1'b1;
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            state   <= (LATENCY == 0) ? READ : WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(1)) state <= READ;
          else lat_cnt <= lat_cnt - LAT_W'(1);
        end
        READ: begin
          blockin[{beat, 5'b00000} +: WORD_BITS] <= rd_word;
          if (beat == 2'(WORDS_PER_LINE - 1)) begin
            beat      <= '0;
            delivered <= 1'b1;
            state     <= DELIVER;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        DELIVER: state <= COOL;
        COOL: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
